imm_extend_unit: RTL and testbench
==================================

// Module: imm_extend_unit
// PURPOSE
// - Parametrised immediate extender for the 16-bit accumulator datapath, a successor to the plain 12->16 sign extender.
// - Adds zero/sign/upper/branch-offset modes and a registered valid/ready stage with a 2-entry skid buffer.
// - Sits between instruction decode (immediate field + mode from control) and the ALU B-mux / PC-offset adder.
// - Lets decode run ahead while the datapath stalls.
// PARAMETERS
// - IN_W   12  width of the immediate field; legal range 2 <= IN_W < OUT_W
// - OUT_W  16  width of the extended result (datapath word)
// PORTS
// - clk       in   1      single clock; all state updates on rising edge
// - rst_n     in   1      asynchronous, active-low reset
// - in_valid  in   1      upstream presents in_imm/in_mode this cycle
// - in_ready  out  1      buffer can accept; transfer when in_valid & in_ready
// - in_imm    in   IN_W   raw immediate field
// - in_mode   in   2      00 zero-ext, 01 sign-ext, 10 upper, 11 branch offset
// - out_valid out  1      out_data/out_err hold a valid entry
// - out_ready in   1      downstream accepts; transfer when out_valid & out_ready
// - out_data  out  OUT_W  extended result
// - out_err   out  1      entry was produced from an unsupported mode
// BEHAVIOUR
// - Extension (combinational, computed at push, stored with the entry):
//   00: {(OUT_W-IN_W){1'b0}, imm}
//   01: {(OUT_W-IN_W){imm[IN_W-1]}, imm}
//   10: imm << (OUT_W-IN_W); the low bits are 0 and the upper bits of imm are kept
//   11: (sign-ext of imm) << 1, truncated to OUT_W; the sign-extended MSB is dropped
//   out_err is 0 for every supported mode.
// - Storage: 2-entry FIFO (skid buffer) built from registers; count is 0..2; entries are {err, data}.
// - in_ready = (count != 2). It is combinational from count only and never depends on in_valid or out_ready.
// - out_valid = (count != 0). out_data/out_err show the head entry; they are 0 when count == 0.
// - Latency: an entry pushed at edge N is visible at out_* after edge N (one cycle) when the buffer was empty.
// - Push only: count+1. Pop only: count-1 and the head advances.
// - Simultaneous push and pop: count unchanged. The pushed entry goes behind the remaining entry, or to the head when count == 1.
// - Push with count == 2 is impossible (in_ready = 0). Pop with count == 0 is ignored.
// - Order is strictly FIFO. No entry is dropped or duplicated under any valid/ready pattern.
// - Upstream must hold in_imm/in_mode stable while in_valid & !in_ready. Downstream may drop out_ready at any cycle.
// - Reset (asserted at any time, including mid-transfer): count = 0, storage = 0, out_valid = 0, out_data = 0, out_err = 0, in_ready = 1.
// - Release of rst_n is synchronous to clk by the system reset controller.
// CONFIGURATION
// - Macro IMM_SHIFT_EN.
// - Defined: modes 10 and 11 behave as listed above.
// - Undefined: modes 10 and 11 produce the sign-ext result (as mode 01) with out_err = 1. The shifter logic is not built.
// - Handshake and buffering are identical in both builds.
// TESTING (IN_W=12, OUT_W=16, IMM_SHIFT_EN defined unless noted)
// - Modes, out_ready=1: imm 0x800 mode 01 -> 0xF800; mode 00 -> 0x0800; mode 10 -> 0x8000; mode 11 imm 0xFFF -> 0xFFFE.
//   Each result appears 1 cycle after the push and out_err = 0.
// - Backpressure: out_ready=0, push 0x001, 0x002 (mode 01) -> in_ready = 0 after 2nd push; the 3rd offer is held.
//   Raise out_ready -> outputs 0x0001, 0x0002, then the 3rd value, in order.
// - Simultaneous push and pop at count == 1 for 10 cycles with an incrementing imm -> count stays 1, no gaps, no duplicates, order preserved.
// - Reset mid-stream: count == 2, assert rst_n=0 between edges -> out_valid = 0, out_data = 0, in_ready = 1 immediately; no stale entry after release.
// - Macro undefined: imm 0x123 mode 10 -> out_data 0x0123, out_err = 1; mode 01 -> 0x0123, out_err = 0.
// - Random valid/ready (1000 transfers) -> scoreboard matches the reference model exactly; in_ready never 0 while count < 2.

Source files
------------

// File: rtl/imm_extend_if.sv
// imm_extend_if: valid/ready bundle between instruction decode and the
// immediate extender output consumer (ALU B-mux / PC-offset adder).
// slave  : seen by imm_extend_unit
// master : seen by the driver of in_* and the consumer of out_*
interface imm_extend_if #(
    parameter int unsigned IN_W  = 12,
    parameter int unsigned OUT_W = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [IN_W-1:0]   in_imm;
    logic [1:0]        in_mode;
    logic              out_valid;
    logic              out_ready;
    logic [OUT_W-1:0]  out_data;
    logic              out_err;

    modport slave (
        input  in_valid,
        input  in_imm,
        input  in_mode,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output out_err
    );

    modport master (
        output in_valid,
        output in_imm,
        output in_mode,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_err
    );
endinterface

// File: rtl/imm_extend_unit.sv
// imm_extend_unit: parametrised immediate extender with a registered
// valid/ready stage backed by a 2-entry skid buffer.
// Modes: 00 zero-ext, 01 sign-ext, 10 upper, 11 branch offset (sext << 1).
// Optional feature macro: IMM_SHIFT_EN
//   defined   : modes 10/11 produce the upper / branch-offset results
//   undefined : modes 10/11 produce the sign-ext result with out_err = 1,
//               and no shifter logic is built
// Entries are stored as {err, data}; the head always lives in ent0 so the
// outputs come straight from one register.
module imm_extend_unit #(
    parameter int unsigned IN_W  = 12,
    parameter int unsigned OUT_W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    imm_extend_if.slave  bus
);

    localparam int unsigned EXT_W = OUT_W - IN_W;

    if (!(IN_W >= 2 && IN_W < OUT_W)) begin : g_bad_width
        $error("imm_extend_unit: need 2 <= IN_W < OUT_W");
    end

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [OUT_W:0]     ent0, ent1;
    logic [OUT_W:0]     ent0_nxt, ent1_nxt;
    logic [OUT_W:0]     new_ent;
    logic [OUT_W-1:0]   zext, sext;
`ifdef IMM_SHIFT_EN
    logic [OUT_W-1:0]   upper, boff;
`endif
    logic               in_rdy, out_vld;
    logic               push, pop;

    // Extension of the incoming immediate; result is captured at push time.
    always_comb begin
        zext    = {{EXT_W{1'b0}}, bus.in_imm};
        sext    = {{EXT_W{bus.in_imm[IN_W-1]}}, bus.in_imm};
`ifdef IMM_SHIFT_EN
        upper   = {bus.in_imm, {EXT_W{1'b0}}};
        boff    = {sext[OUT_W-2:0], 1'b0};
`endif
        new_ent = {1'b0, zext};
        case (bus.in_mode)
            2'b00:   new_ent = {1'b0, zext};
            2'b01:   new_ent = {1'b0, sext};
`ifdef IMM_SHIFT_EN
            2'b10:   new_ent = {1'b0, upper};
            default: new_ent = {1'b0, boff};
`else
            default: new_ent = {1'b1, sext};
`endif
        endcase
    end

    assign in_rdy = (state != S_FULL);
    assign out_vld = (state != S_EMPTY);
    assign push = bus.in_valid && in_rdy;
    assign pop = out_vld && bus.out_ready;

    // Occupancy state, head entry and second entry registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_EMPTY;
            ent0  <= '0;
            ent1  <= '0;
        end else begin
            state <= state_nxt;
            ent0  <= ent0_nxt;
            ent1  <= ent1_nxt;
        end
    end

    // Next occupancy and entry contents; vacated slots are cleared so an
    // empty buffer always presents zeros.
    always_comb begin
        state_nxt = state;
        ent0_nxt  = ent0;
        ent1_nxt  = ent1;
        case (state)
            S_EMPTY: begin
                if (push) begin
                    ent0_nxt  = new_ent;
                    state_nxt = S_ONE;
                end
            end
            S_ONE: begin
                case ({push, pop})
                    2'b10: begin
                        ent1_nxt  = new_ent;
                        state_nxt = S_FULL;
                    end
                    2'b01: begin
                        ent0_nxt  = '0;
                        state_nxt = S_EMPTY;
                    end
                    2'b11: begin
                        ent0_nxt  = new_ent;
                    end
                    default: begin
                        state_nxt = S_ONE;
                    end
                endcase
            end
            S_FULL: begin
                if (pop) begin
                    ent0_nxt  = ent1;
                    ent1_nxt  = '0;
                    state_nxt = S_ONE;
                end
            end
            default: begin
                ent0_nxt  = '0;
                ent1_nxt  = '0;
                state_nxt = S_EMPTY;
            end
        endcase
    end

    assign bus.in_ready  = in_rdy;
    assign bus.out_valid = out_vld;
    assign bus.out_data  = out_vld ? ent0[OUT_W-1:0] : '0;
    assign bus.out_err   = out_vld ? ent0[OUT_W] : 1'b0;

endmodule

// File: tb/tb_imm_extend_unit.sv
// tb_imm_extend_unit: directed and randomised checks of imm_extend_unit
// with IN_W=12, OUT_W=16. Expected values follow IMM_SHIFT_EN.
module tb_imm_extend_unit;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    imm_extend_if #(.IN_W(12), .OUT_W(16)) ifc ();

    imm_extend_unit #(.IN_W(12), .OUT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference extension written arithmetically: returns {err, data}.
    function automatic logic [16:0] ref_ext(input logic [11:0] imm, input logic [1:0] mode);
        int s;
        int u;
        s = int'($signed(imm));
        u = int'(imm);
        case (mode)
            2'd0: return {1'b0, 16'(u)};
            2'd1: return {1'b0, 16'(s)};
`ifdef IMM_SHIFT_EN
            2'd2: return {1'b0, 16'(u * 16)};
            default: return {1'b0, 16'(s * 2)};
`else
            default: return {1'b1, 16'(s)};
`endif
        endcase
    endfunction

    task automatic test_reset();
        checks++;
        if (ifc.out_valid !== 1'b0 || ifc.in_ready !== 1'b1 ||
            ifc.out_data !== 16'h0000 || ifc.out_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got v=%b r=%b d=%h e=%b, want v=0 r=1 d=0000 e=0",
                     ifc.out_valid, ifc.in_ready, ifc.out_data, ifc.out_err);
        end
    endtask

    task automatic test_modes();
        logic [11:0] imms  [7];
        logic [1:0]  modes [7];
        logic [15:0] edata [7];
        logic        eerr  [7];
        imms = '{12'h800, 12'h800, 12'h800, 12'hFFF, 12'h123, 12'h123, 12'h123};
        modes = '{2'd1, 2'd0, 2'd2, 2'd3, 2'd2, 2'd1, 2'd3};
`ifdef IMM_SHIFT_EN
        edata = '{16'hF800, 16'h0800, 16'h8000, 16'hFFFE, 16'h1230, 16'h0123, 16'h0246};
        eerr  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`else
        edata = '{16'hF800, 16'h0800, 16'hF800, 16'hFFFF, 16'h0123, 16'h0123, 16'h0123};
        eerr  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
`endif
        ifc.out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            ifc.in_valid = 1'b1;
            ifc.in_imm   = imms[i];
            ifc.in_mode  = modes[i];
            tick();
            ifc.in_valid = 1'b0;
            checks++;
            if (ifc.out_valid !== 1'b1 || ifc.out_data !== edata[i] || ifc.out_err !== eerr[i]) begin
                errors++;
                $display("FAIL mode_vec%0d: got v=%b d=%h e=%b, want v=1 d=%h e=%b",
                         i, ifc.out_valid, ifc.out_data, ifc.out_err, edata[i], eerr[i]);
            end
            tick();
            checks++;
            if (ifc.out_valid !== 1'b0 || ifc.out_data !== 16'h0000) begin
                errors++;
                $display("FAIL mode_drain%0d: got v=%b d=%h, want v=0 d=0000",
                         i, ifc.out_valid, ifc.out_data);
            end
        end
    endtask

    task automatic test_backpressure();
        ifc.out_ready = 1'b0;
        ifc.in_mode   = 2'd1;
        ifc.in_valid  = 1'b1;
        ifc.in_imm    = 12'h001;
        tick();
        checks++;
        if (ifc.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_ready_after1: got %b, want 1", ifc.in_ready);
        end
        ifc.in_imm = 12'h002;
        tick();
        checks++;
        if (ifc.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_ready_after2: got %b, want 0", ifc.in_ready);
        end
        ifc.in_imm = 12'h003;
        for (int k = 0; k < 2; k++) begin
            tick();
            checks++;
            if (ifc.in_ready !== 1'b0 || ifc.out_data !== 16'h0001) begin
                errors++;
                $display("FAIL bp_hold%0d: got r=%b d=%h, want r=0 d=0001", k, ifc.in_ready, ifc.out_data);
            end
        end
        ifc.out_ready = 1'b1;
        tick();
        checks++;
        if (ifc.out_valid !== 1'b1 || ifc.out_data !== 16'h0002 || ifc.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_second: got v=%b d=%h r=%b, want v=1 d=0002 r=1",
                     ifc.out_valid, ifc.out_data, ifc.in_ready);
        end
        tick();
        ifc.in_valid = 1'b0;
        checks++;
        if (ifc.out_valid !== 1'b1 || ifc.out_data !== 16'h0003) begin
            errors++;
            $display("FAIL bp_third: got v=%b d=%h, want v=1 d=0003", ifc.out_valid, ifc.out_data);
        end
        tick();
        checks++;
        if (ifc.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_drained: got v=%b, want 0", ifc.out_valid);
        end
    endtask

    task automatic test_back_to_back();
        ifc.out_ready = 1'b0;
        ifc.in_mode   = 2'd0;
        ifc.in_valid  = 1'b1;
        ifc.in_imm    = 12'h100;
        tick();
        ifc.out_ready = 1'b1;
        ifc.in_imm    = 12'h101;
        checks++;
        if (ifc.out_data !== 16'h0100) begin
            errors++;
            $display("FAIL b2b_first: got %h, want 0100", ifc.out_data);
        end
        for (int i = 1; i <= 10; i++) begin
            tick();
            checks++;
            if (ifc.out_valid !== 1'b1 || ifc.in_ready !== 1'b1 ||
                ifc.out_data !== 16'(16'h0100 + i)) begin
                errors++;
                $display("FAIL b2b_step%0d: got v=%b r=%b d=%h, want v=1 r=1 d=%h",
                         i, ifc.out_valid, ifc.in_ready, ifc.out_data, 16'(16'h0100 + i));
            end
            if (i < 10) ifc.in_imm = 12'(12'h100 + i + 1);
            else        ifc.in_valid = 1'b0;
        end
        tick();
        checks++;
        if (ifc.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_drained: got v=%b, want 0", ifc.out_valid);
        end
    endtask

    task automatic test_reset_midstream();
        ifc.out_ready = 1'b0;
        ifc.in_mode   = 2'd1;
        ifc.in_valid  = 1'b1;
        ifc.in_imm    = 12'hABC;
        tick();
        ifc.in_imm = 12'h555;
        tick();
        ifc.in_valid = 1'b0;
        checks++;
        if (ifc.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_full: got r=%b, want 0", ifc.in_ready);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (ifc.out_valid !== 1'b0 || ifc.out_data !== 16'h0000 ||
            ifc.in_ready !== 1'b1 || ifc.out_err !== 1'b0) begin
            errors++;
            $display("FAIL rst_async: got v=%b d=%h r=%b e=%b, want v=0 d=0000 r=1 e=0",
                     ifc.out_valid, ifc.out_data, ifc.in_ready, ifc.out_err);
        end
        tick();
        rst_n = 1'b1;
        ifc.out_ready = 1'b1;
        tick();
        tick();
        checks++;
        if (ifc.out_valid !== 1'b0 || ifc.out_data !== 16'h0000) begin
            errors++;
            $display("FAIL rst_no_stale: got v=%b d=%h, want v=0 d=0000", ifc.out_valid, ifc.out_data);
        end
        ifc.in_valid = 1'b1;
        ifc.in_imm   = 12'h07F;
        tick();
        ifc.in_valid = 1'b0;
        checks++;
        if (ifc.out_valid !== 1'b1 || ifc.out_data !== 16'h007F) begin
            errors++;
            $display("FAIL rst_fresh: got v=%b d=%h, want v=1 d=007F", ifc.out_valid, ifc.out_data);
        end
        tick();
    endtask

    task automatic test_random();
        logic [16:0] q[$];
        logic        pending;
        logic        push, pop;
        int          popped;
        int          cycles;
        int          shown;
        pending = 1'b0;
        popped  = 0;
        cycles  = 0;
        shown   = 0;
        ifc.in_valid  = 1'b0;
        ifc.out_ready = 1'b0;
        while (popped < 1000 && cycles < 20000) begin
            cycles++;
            checks++;
            if (ifc.in_ready !== (q.size() < 2) || ifc.out_valid !== (q.size() != 0) ||
                (q.size() != 0 && {ifc.out_err, ifc.out_data} !== q[0])) begin
                errors++;
                if (shown < 20) begin
                    shown++;
                    $display("FAIL rand_cycle%0d: got r=%b v=%b ed=%h, want r=%b v=%b ed=%h",
                             cycles, ifc.in_ready, ifc.out_valid, {ifc.out_err, ifc.out_data},
                             q.size() < 2, q.size() != 0, (q.size() != 0) ? q[0] : 17'h0);
                end
            end
            if (!pending) begin
                ifc.in_valid = ($urandom_range(0, 9) < 6);
                ifc.in_imm   = 12'($urandom_range(0, 4095));
                ifc.in_mode  = 2'($urandom_range(0, 3));
            end
            ifc.out_ready = ($urandom_range(0, 9) < 6);
            push = ifc.in_valid && (q.size() < 2);
            pop  = ifc.out_ready && (q.size() != 0);
            tick();
            if (pop) begin
                void'(q.pop_front());
                popped++;
            end
            if (push) q.push_back(ref_ext(ifc.in_imm, ifc.in_mode));
            pending = ifc.in_valid && !push;
        end
        ifc.in_valid  = 1'b0;
        ifc.out_ready = 1'b1;
        checks++;
        if (popped < 1000) begin
            errors++;
            $display("FAIL rand_budget: got %0d transfers, want 1000", popped);
        end
        tick();
        tick();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        ifc.in_valid  = 1'b0;
        ifc.in_imm    = '0;
        ifc.in_mode   = '0;
        ifc.out_ready = 1'b0;
        tick();
        test_reset();
        tick();
        rst_n = 1'b1;
        tick();
        test_modes();
        test_backpressure();
        test_back_to_back();
        test_reset_midstream();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
